// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse packet decoder.
// Status-byte bit positions, FSM state encoding and default screen limits.
package mouse_pkg;

  typedef enum logic [1:0] {
    ST_B0,
    ST_B1,
    ST_B2,
    ST_UPD
  } state_t;

  typedef logic [11:0] pos_t;

  localparam int STS_LEFT   = 0;
  localparam int STS_RIGHT  = 1;
  localparam int STS_SYNC   = 3;
  localparam int STS_X_SIGN = 4;
  localparam int STS_Y_SIGN = 5;
  localparam int STS_X_OVF  = 6;
  localparam int STS_Y_OVF  = 7;

  localparam int X_MAX_DEF = 799;
  localparam int Y_MAX_DEF = 599;

  typedef struct packed {
    logic y_ovf;
    logic x_ovf;
    logic y_sign;
    logic x_sign;
    logic right;
    logic left;
  } status_t;

endpackage

// File: rtl/mouse_axis_clamp.sv
// One cursor axis: pos + signed delta, delta zeroed on overflow, result clamped to [0, MAX].
// The delta port is 10 bits so the negated Y delta (up to +256) still fits.
module mouse_axis_clamp #(
  parameter int MAX = 799
) (
  input  logic [11:0]       pos,
  input  logic signed [9:0] delta,
  input  logic              ovf,
  output logic [11:0]       pos_new
);

  localparam logic signed [13:0] MAX_S = 14'(MAX);

  logic signed [13:0] delta_ext;
  logic signed [13:0] sum;

  always_comb begin
    delta_ext = ovf ? 14'sd0 : $signed({{4{delta[9]}}, delta});
    sum       = $signed({2'b00, pos}) + delta_ext;
    pos_new   = sum[11:0];
    if (sum < 14'sd0) begin
      pos_new = '0;
    end else if (sum > MAX_S) begin
      pos_new = MAX_S[11:0];
    end
  end

endmodule

// File: rtl/mouse_decoder.sv
// PS/2 mouse decoder: assembles 3-byte packets and integrates them into a clamped cursor.
// Define MOUSE_TIMEOUT_EN to compile in the inter-byte timeout and its abort path.
//
// state | meaning
// B0    | await status byte (bit3 must be 1)
// B1    | await X delta byte
// B2    | await Y delta byte
// UPD   | apply packet to outputs; an incoming byte is treated as a new status byte
module mouse_decoder
  import mouse_pkg::*;
#(
  parameter int X_MAX       = X_MAX_DEF,
  parameter int Y_MAX       = Y_MAX_DEF,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        left,
  output logic        right,
  output logic        pkt_done,
  output logic        sync_err
);

  state_t  state_q, state_d;
  status_t sts_q, sts_d;
  logic [7:0] dx_q, dx_d, dy_q, dy_d;
  pos_t xpos_q, xpos_d, ypos_q, ypos_d;
  logic left_q, left_d, right_q, right_d;
  logic pkt_done_q, pkt_done_d, sync_err_q, sync_err_d;

  logic timeout_hit;
  logic b0_byte;
  logic signed [9:0] dx_ext, dy_neg;
  pos_t x_new, y_new;
  logic unused_rx_bit2;

  assign unused_rx_bit2 = rx_data[2];

`ifdef MOUSE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic in_pkt;

  always_comb begin
    in_pkt      = (state_q == ST_B1) || (state_q == ST_B2);
    timeout_hit = in_pkt && (cnt_q == CNT_LAST);
    cnt_d       = '0;
    if (in_pkt && !rx_valid && !timeout_hit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign timeout_hit    = 1'b0;
`endif

  // Y is negated before clamping: PS/2 reports up-positive, the screen grows downward.
  assign dx_ext = {sts_q.x_sign, sts_q.x_sign, dx_q};
  assign dy_neg = -$signed({sts_q.y_sign, sts_q.y_sign, dy_q});

  mouse_axis_clamp #(.MAX(X_MAX)) u_x_clamp (
    .pos     (xpos_q),
    .delta   (dx_ext),
    .ovf     (sts_q.x_ovf),
    .pos_new (x_new)
  );

  mouse_axis_clamp #(.MAX(Y_MAX)) u_y_clamp (
    .pos     (ypos_q),
    .delta   (dy_neg),
    .ovf     (sts_q.y_ovf),
    .pos_new (y_new)
  );

  always_comb begin
    state_d    = state_q;
    sts_d      = sts_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    xpos_d     = xpos_q;
    ypos_d     = ypos_q;
    left_d     = left_q;
    right_d    = right_q;
    pkt_done_d = 1'b0;
    sync_err_d = 1'b0;
    b0_byte    = 1'b0;

    unique case (state_q)
      ST_B0: b0_byte = rx_valid;
      ST_B1: begin
        if (timeout_hit) begin
          sync_err_d = 1'b1;
          state_d    = ST_B0;
          b0_byte    = rx_valid;
        end else if (rx_valid) begin
          dx_d    = rx_data;
          state_d = ST_B2;
        end
      end
      ST_B2: begin
        if (timeout_hit) begin
          sync_err_d = 1'b1;
          state_d    = ST_B0;
          b0_byte    = rx_valid;
        end else if (rx_valid) begin
          dy_d    = rx_data;
          state_d = ST_UPD;
        end
      end
      ST_UPD: begin
        xpos_d     = x_new;
        ypos_d     = y_new;
        left_d     = sts_q.left;
        right_d    = sts_q.right;
        pkt_done_d = 1'b1;
        state_d    = ST_B0;
        b0_byte    = rx_valid;
      end
      default: state_d = ST_B0;
    endcase

    if (b0_byte) begin
      if (rx_data[STS_SYNC]) begin
        sts_d.left   = rx_data[STS_LEFT];
        sts_d.right  = rx_data[STS_RIGHT];
        sts_d.x_sign = rx_data[STS_X_SIGN];
        sts_d.y_sign = rx_data[STS_Y_SIGN];
        sts_d.x_ovf  = rx_data[STS_X_OVF];
        sts_d.y_ovf  = rx_data[STS_Y_OVF];
        state_d      = ST_B1;
      end else begin
        sync_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q    <= ST_B0;
      sts_q      <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      xpos_q     <= '0;
      ypos_q     <= '0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      pkt_done_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sts_q      <= sts_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
      left_q     <= left_d;
      right_q    <= right_d;
      pkt_done_q <= pkt_done_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign xpos     = xpos_q;
  assign ypos     = ypos_q;
  assign left     = left_q;
  assign right    = right_q;
  assign pkt_done = pkt_done_q;
  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_mouse_decoder.sv
// Self-checking bench for mouse_decoder with a behavioural cursor model.
// Timeout behaviour checked when MOUSE_TIMEOUT_EN is defined, indefinite wait otherwise.
module tb_mouse_decoder;

  logic        pclk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [11:0] xpos, ypos;
  logic        left, right, pkt_done, sync_err;

  int checks   = 0;
  int failures = 0;
  int pkt_cnt  = 0;
  int err_cnt  = 0;

  int   mx, my;
  logic ml, mr;

  mouse_decoder #(.X_MAX(799), .Y_MAX(599), .TIMEOUT_CYC(100)) dut (
    .pclk     (pclk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .xpos     (xpos),
    .ypos     (ypos),
    .left     (left),
    .right    (right),
    .pkt_done (pkt_done),
    .sync_err (sync_err)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    #2;
    if (pkt_done === 1'b1) pkt_cnt++;
    if (sync_err === 1'b1) err_cnt++;
  end

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic void model_pkt(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b);
    int dx, dy;
    dx = s[6] ? 0 : (s[4] ? int'(a) - 256 : int'(a));
    dy = s[7] ? 0 : (s[5] ? int'(b) - 256 : int'(b));
    mx = clampi(mx + dx, 799);
    my = clampi(my - dy, 599);
    ml = s[0];
    mr = s[1];
  endfunction

  task automatic drive_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge pclk);
    rx_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int gap);
    drive_byte(b0);
    repeat (gap) @(negedge pclk);
    drive_byte(b1);
    repeat (gap) @(negedge pclk);
    drive_byte(b2);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge pclk);
    checks++;
    if ({xpos, ypos, left, right, pkt_done, sync_err} !== '0) begin
      failures++;
      $display("FAIL reset_hold: got x=%0d y=%0d l=%b r=%b pd=%b se=%b required all 0",
               xpos, ypos, left, right, pkt_done, sync_err);
    end
    rst = 1'b0;
    repeat (2) @(negedge pclk);
    checks++;
    if ({xpos, ypos, left, right, pkt_done, sync_err} !== '0) begin
      failures++;
      $display("FAIL reset_release: got x=%0d y=%0d pd=%b se=%b required all 0",
               xpos, ypos, pkt_done, sync_err);
    end
    mx = 0; my = 0; ml = 0; mr = 0;
  endtask

  task automatic test_basic();
    int base;
    base = pkt_cnt;
    send_packet(8'h09, 8'h0A, 8'h05, 1);
    model_pkt(8'h09, 8'h0A, 8'h05);
    checks++;
    if (pkt_done !== 1'b0) begin
      failures++; $display("FAIL basic_pd_early: got %b required 0", pkt_done);
    end
    @(negedge pclk);
    checks++;
    if (pkt_done !== 1'b1) begin
      failures++; $display("FAIL basic_pd: got %b required 1", pkt_done);
    end
    checks++;
    if (xpos !== 12'd10 || ypos !== 12'd0) begin
      failures++; $display("FAIL basic_pos: got %0d,%0d required 10,0", xpos, ypos);
    end
    checks++;
    if (left !== 1'b1 || right !== 1'b0) begin
      failures++; $display("FAIL basic_btn: got l=%b r=%b required l=1 r=0", left, right);
    end
    @(negedge pclk);
    checks++;
    if (pkt_done !== 1'b0 || pkt_cnt - base !== 1) begin
      failures++; $display("FAIL basic_pulse: got pd=%b pulses=%0d required 0 and 1",
                           pkt_done, pkt_cnt - base);
    end
  endtask

  task automatic test_clamp_high();
    for (int i = 0; i < 8 && (mx != 795 || my != 300); i++) begin
      int tx, ty;
      logic [7:0] s, a, b;
      tx = 795 - mx; if (tx > 255) tx = 255; if (tx < -256) tx = -256;
      ty = my - 300; if (ty > 255) ty = 255; if (ty < -256) ty = -256;
      s = 8'h08 | (tx < 0 ? 8'h10 : 8'h00) | (ty < 0 ? 8'h20 : 8'h00);
      a = tx[7:0];
      b = ty[7:0];
      send_packet(s, a, b, 0);
      model_pkt(s, a, b);
      @(negedge pclk);
    end
    checks++;
    if (xpos !== 12'd795 || ypos !== 12'd300) begin
      failures++; $display("FAIL clamp_setup: got %0d,%0d required 795,300", xpos, ypos);
    end
    send_packet(8'h28, 8'h14, 8'hF6, 0);
    model_pkt(8'h28, 8'h14, 8'hF6);
    @(negedge pclk);
    checks++;
    if (xpos !== 12'd799 || ypos !== 12'd310 || pkt_done !== 1'b1) begin
      failures++; $display("FAIL clamp_high: got %0d,%0d pd=%b required 799,310 pd=1",
                           xpos, ypos, pkt_done);
    end
  endtask

  task automatic test_sync_err();
    int base;
    base = pkt_cnt;
    drive_byte(8'h00);
    checks++;
    if (sync_err !== 1'b1) begin
      failures++; $display("FAIL sync_err_pulse: got %b required 1", sync_err);
    end
    @(negedge pclk);
    checks++;
    if (sync_err !== 1'b0) begin
      failures++; $display("FAIL sync_err_single: got %b required 0", sync_err);
    end
    send_packet(8'h08, 8'h01, 8'h01, 2);
    model_pkt(8'h08, 8'h01, 8'h01);
    @(negedge pclk);
    checks++;
    if (xpos !== 12'(mx) || ypos !== 12'(my) || pkt_cnt - base !== 1) begin
      failures++; $display("FAIL sync_recover: got %0d,%0d pulses=%0d required %0d,%0d pulses=1",
                           xpos, ypos, pkt_cnt - base, mx, my);
    end
  endtask

  task automatic test_overflow();
    int x0;
    x0 = mx;
    send_packet(8'h48, 8'h7F, 8'h02, 1);
    model_pkt(8'h48, 8'h7F, 8'h02);
    @(negedge pclk);
    checks++;
    if (xpos !== 12'(x0) || ypos !== 12'(my) || pkt_done !== 1'b1) begin
      failures++; $display("FAIL overflow: got %0d,%0d pd=%b required %0d,%0d pd=1",
                           xpos, ypos, pkt_done, x0, my);
    end
  endtask

  task automatic test_back_to_back();
    send_packet(8'h08, 8'h05, 8'h00, 0);
    model_pkt(8'h08, 8'h05, 8'h00);
    drive_byte(8'h19);
    checks++;
    if (xpos !== 12'(mx) || pkt_done !== 1'b1) begin
      failures++; $display("FAIL b2b_first: got x=%0d pd=%b required x=%0d pd=1", xpos, pkt_done, mx);
    end
    drive_byte(8'hFD);
    drive_byte(8'h00);
    model_pkt(8'h19, 8'hFD, 8'h00);
    @(negedge pclk);
    checks++;
    if (xpos !== 12'(mx) || left !== ml || pkt_done !== 1'b1) begin
      failures++; $display("FAIL b2b_second: got x=%0d l=%b pd=%b required x=%0d l=%b pd=1",
                           xpos, left, pkt_done, mx, ml);
    end
  endtask

  task automatic test_timeout();
    int base_p, base_e;
    base_p = pkt_cnt;
    base_e = err_cnt;
    drive_byte(8'h08);
    drive_byte(8'h10);
`ifdef MOUSE_TIMEOUT_EN
    repeat (100) @(negedge pclk);
    checks++;
    if (sync_err !== 1'b1 || err_cnt - base_e !== 1 || pkt_cnt != base_p) begin
      failures++; $display("FAIL timeout_abort: got se=%b errs=%0d pkts=%0d required 1,1,0",
                           sync_err, err_cnt - base_e, pkt_cnt - base_p);
    end
    @(negedge pclk);
    send_packet(8'h08, 8'h03, 8'h00, 0);
    model_pkt(8'h08, 8'h03, 8'h00);
`else
    repeat (150) @(negedge pclk);
    checks++;
    if (err_cnt != base_e || pkt_cnt != base_p) begin
      failures++; $display("FAIL no_timeout_wait: got errs=%0d pkts=%0d required 0,0",
                           err_cnt - base_e, pkt_cnt - base_p);
    end
    drive_byte(8'h00);
    model_pkt(8'h08, 8'h10, 8'h00);
`endif
    @(negedge pclk);
    checks++;
    if (xpos !== 12'(mx) || ypos !== 12'(my) || pkt_done !== 1'b1) begin
      failures++; $display("FAIL timeout_next: got %0d,%0d pd=%b required %0d,%0d pd=1",
                           xpos, ypos, pkt_done, mx, my);
    end
  endtask

  task automatic test_reset_midpacket();
    int base_p, base_e;
    drive_byte(8'h0B);
    base_p = pkt_cnt;
    base_e = err_cnt;
    rst = 1'b1;
    repeat (2) @(negedge pclk);
    rst = 1'b0;
    @(negedge pclk);
    checks++;
    if ({xpos, ypos, left, right, pkt_done, sync_err} !== '0 ||
        pkt_cnt != base_p || err_cnt != base_e) begin
      failures++; $display("FAIL reset_mid: got x=%0d y=%0d pulses=%0d/%0d required 0,0 0/0",
                           xpos, ypos, pkt_cnt - base_p, err_cnt - base_e);
    end
    mx = 0; my = 0; ml = 0; mr = 0;
    send_packet(8'h29, 8'h05, 8'hFB, 0);
    model_pkt(8'h29, 8'h05, 8'hFB);
    @(negedge pclk);
    checks++;
    if (xpos !== 12'd5 || ypos !== 12'd5 || left !== 1'b1 || pkt_done !== 1'b1) begin
      failures++; $display("FAIL reset_mid_next: got %0d,%0d l=%b pd=%b required 5,5 l=1 pd=1",
                           xpos, ypos, left, pkt_done);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [7:0] s, a, b, bad;
      if ($urandom_range(0, 3) == 0) begin
        bad = 8'($urandom) & 8'hF7;
        drive_byte(bad);
        checks++;
        if (sync_err !== 1'b1) begin
          failures++; $display("FAIL rand_bad_status %0d: got se=%b required 1", i, sync_err);
        end
      end
      s = 8'($urandom) | 8'h08;
      a = 8'($urandom);
      b = 8'($urandom);
      send_packet(s, a, b, $urandom_range(0, 2));
      model_pkt(s, a, b);
      @(negedge pclk);
      checks++;
      if (xpos !== 12'(mx) || ypos !== 12'(my) || left !== ml || right !== mr ||
          pkt_done !== 1'b1) begin
        failures++;
        $display("FAIL rand_pkt %0d (%h %h %h): got %0d,%0d l=%b r=%b pd=%b required %0d,%0d l=%b r=%b pd=1",
                 i, s, a, b, xpos, ypos, left, right, pkt_done, mx, my, ml, mr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp_high();
    test_sync_err();
    test_overflow();
    test_back_to_back();
    test_timeout();
    test_reset_midpacket();
    test_random();
    repeat (2) @(negedge pclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
